// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake direction controller.
package snake_pkg;

  localparam int unsigned DIR_W = 2;
  localparam int unsigned CNT_W = 3;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd1;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd2;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } snake_state_e;

  // Reverse heading: UP<->DOWN, RIGHT<->LEFT differ only in bit 1.
  function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small circular FIFO with flush, same-cycle push/pop and a last-entry peek.
module dir_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head_c,
  output logic [WIDTH-1:0] last_c,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] last_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  // Guard against underflow, and allow a push into a full buffer only alongside a pop.
  always_comb begin
    do_pop   = pop && (count != '0);
    do_push  = push && ((count != CNT_MAX) || do_pop);
    last_ptr = (wr_ptr == '0) ? PTR_MAX : wr_ptr - PTR_W'(1);
    head_c   = mem[rd_ptr];
    last_c   = mem[last_ptr];
  end

  // Pointer and occupancy bookkeeping; flush wins over any same-cycle traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/snake_direction_ctrl.sv
// Turn buffering, reversal filtering and run/pause state for the snake.
module snake_direction_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned      QUEUE_DEPTH = 2,
  parameter logic [DIR_W-1:0] INIT_DIR    = 2'd1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             BtnUp,
  input  logic             BtnRight,
  input  logic             BtnDown,
  input  logic             BtnLeft,
  input  logic             BtnPause,
  input  logic             Restart,
  input  logic             Tick,
  output logic [DIR_W-1:0] Direction,
  output logic             Turned,
  output logic             Running,
  output logic [CNT_W-1:0] QueueCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUEUE_DEPTH);

  snake_state_e     state_q;
  snake_state_e     state_d;
  logic [DIR_W-1:0] dir_q;
  logic             turned_q;
  logic             running_q;

  logic [DIR_W-1:0] press_dir;
  logic             press_vld;
  logic [DIR_W-1:0] ref_dir;
  logic             tick_pop;
  logic             press_ok;
  logic             do_push;
  logic             do_pop;
  logic             flush;

  logic [DIR_W-1:0] q_head;
  logic [DIR_W-1:0] q_last;
  logic [CNT_W-1:0] q_count;

  dir_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (DIR_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .flush  (flush),
    .push   (do_push),
    .pop    (do_pop),
    .din    (press_dir),
    .head_c (q_head),
    .last_c (q_last),
    .count  (q_count)
  );

  // Fixed-priority pick of a single press: Up > Right > Down > Left.
  always_comb begin
    press_vld = BtnUp | BtnRight | BtnDown | BtnLeft;
    press_dir = DIR_LEFT;
    if (BtnUp)         press_dir = DIR_UP;
    else if (BtnRight) press_dir = DIR_RIGHT;
    else if (BtnDown)  press_dir = DIR_DOWN;
  end

  // Reference heading and acceptance test, both taken before any same-cycle pop.
  always_comb begin
    ref_dir  = (q_count != '0) ? q_last : dir_q;
    tick_pop = (state_q == ST_RUN) && Tick && !BtnPause && !Restart && (q_count != '0);
    press_ok = press_vld && (press_dir != ref_dir) && (press_dir != opposite(ref_dir)) &&
               ((q_count != CNT_MAX) || tick_pop);
  end

  // FSM next state and queue control.
  always_comb begin
    state_d = state_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    flush   = 1'b0;
    if (Restart) begin
      flush   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (press_ok) begin
            do_push = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          do_pop  = tick_pop;
          do_push = press_ok;
          if (BtnPause) state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (BtnPause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Committed heading, one-cycle turn pulse and run flag.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_q     <= INIT_DIR;
      turned_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      running_q <= (state_d == ST_RUN);
      turned_q  <= do_pop;
      if (Restart)     dir_q <= INIT_DIR;
      else if (do_pop) dir_q <= q_head;
    end
  end

  assign Direction  = dir_q;
  assign Turned     = turned_q;
  assign Running    = running_q;
  assign QueueCount = q_count;

endmodule

// File: tb/tb_snake_direction_ctrl.sv
// Randomised and directed bench for snake_direction_ctrl against a queue-based model.
module tb_snake_direction_ctrl;

  localparam int       DEPTH = 2;
  localparam bit [1:0] INIT  = 2'd1;
  localparam int       S_IDLE = 0, S_RUN = 1, S_PAUSED = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 0, right = 0, down = 0, left = 0, pause = 0, restart = 0, tick = 0;
  logic [1:0] dir;
  logic       turned, running;
  logic [2:0] qcount;

  int         n_vec = 0;
  int         n_err = 0;

  int         m_state;
  bit [1:0]   m_dir;
  bit         m_turned;
  bit [1:0]   m_q[$];

  snake_direction_ctrl #(.QUEUE_DEPTH(DEPTH), .INIT_DIR(INIT)) dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .BtnUp      (up),
    .BtnRight   (right),
    .BtnDown    (down),
    .BtnLeft    (left),
    .BtnPause   (pause),
    .Restart    (restart),
    .Tick       (tick),
    .Direction  (dir),
    .Turned     (turned),
    .Running    (running),
    .QueueCount (qcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state  = S_IDLE;
    m_dir    = INIT;
    m_turned = 0;
    m_q.delete();
  endfunction

  // Game rules applied to the model for one clock edge.
  function automatic void model_step(input bit u, r, d, l, p, rs, t);
    bit [1:0] pd, rf;
    bit has, pop, ok;
    m_turned = 0;
    if (rs) begin
      model_reset();
      return;
    end
    has = u | r | d | l;
    pd  = u ? 2'd0 : r ? 2'd1 : d ? 2'd2 : 2'd3;
    rf  = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
    pop = (m_state == S_RUN) && t && !p && (m_q.size() > 0);
    ok  = has && (pd != rf) && (pd != (rf ^ 2'b10)) && ((m_q.size() - int'(pop)) < DEPTH);
    case (m_state)
      S_IDLE: if (ok) begin m_q.push_back(pd); m_state = S_RUN; end
      S_RUN: begin
        if (pop) begin m_dir = m_q.pop_front(); m_turned = 1; end
        if (ok) m_q.push_back(pd);
        if (p) m_state = S_PAUSED;
      end
      default: if (p) m_state = S_RUN;
    endcase
  endfunction

  task automatic check_outputs();
    check("dir", int'(dir), int'(m_dir));
    check("turned", int'(turned), int'(m_turned));
    check("running", int'(running), int'(m_state == S_RUN));
    check("count", int'(qcount), m_q.size());
  endtask

  // Drive one cycle of inputs at the falling edge, then compare after the rising edge.
  task automatic cycle(input bit u, r, d, l, p, rs, t);
    up = u; right = r; down = d; left = l; pause = p; restart = rs; tick = t;
    model_step(u, r, d, l, p, rs, t);
    @(posedge clk);
    @(negedge clk);
    up = 0; right = 0; down = 0; left = 0; pause = 0; restart = 0; tick = 0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Idle ticks change nothing.
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 1);
    check("t1_dir", int'(dir), 1);
    check("t1_running", int'(running), 0);

    // First press starts the game; tick commits it.
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("t2_running", int'(running), 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("t2_dir", int'(dir), 0);
    check("t2_turned", int'(turned), 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("t2_turned_drop", int'(turned), 0);

    // Get to RUN heading RIGHT, then reversal and opposite-of-queued rejection.
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("t3_heading", int'(dir), 1);
    cycle(0, 0, 0, 1, 0, 0, 0);
    check("t3_left_rej", int'(qcount), 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    check("t3_down_rej", int'(qcount), 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("t3_dir", int'(dir), 0);

    // Full queue, simultaneous pop and push.
    cycle(0, 1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("t4_heading", int'(dir), 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    check("t4_full", int'(qcount), 2);
    cycle(0, 0, 1, 0, 0, 0, 1);
    check("t4_popush_cnt", int'(qcount), 2);
    check("t4_popush_dir", int'(dir), 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("t4_dir_left", int'(dir), 3);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("t4_dir_down", int'(dir), 2);

    // Same-cycle Up and Left while heading RIGHT.
    cycle(0, 1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 0, 0, 0);
    check("t5_count", int'(qcount), 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("t5_dir", int'(dir), 0);

    // Pause freezes, restart clears.
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 1);
    check("t6_pause_cnt", int'(qcount), 2);
    check("t6_pause_dir", int'(dir), 0);
    check("t6_pause_run", int'(running), 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("t6_restart_cnt", int'(qcount), 0);
    check("t6_restart_dir", int'(dir), 1);

    // Asynchronous reset in the middle of a tick cycle.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    tick = 1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_dir", int'(dir), 1);
    check("rst_turned", int'(turned), 0);
    check("rst_running", int'(running), 0);
    check("rst_count", int'(qcount), 0);
    model_reset();
    @(negedge clk);
    tick  = 0;
    rst_n = 1'b1;
    check_outputs();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 25) == 0, $urandom_range(0, 150) == 0,
            $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
